m_mem_read_arbiter: RTL and testbench

- Owns the single read port of the modulus ROM (registered single-port M4K, 2-cycle read latency).
- Shares that port between two requesters, e.g. the Montgomery multiplier and the pre-computation unit.
- Each requester asks for a burst of consecutive words. The block grants round-robin, issues one address per cycle, and returns tagged data with a last marker and a per-requester done pulse.

---
 rtl/m_mem_read_arbiter_pkg.sv | 22 ++
 rtl/m_mem_rr_arbiter.sv | 44 ++++
 rtl/m_mem_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_m_mem_read_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_mem_read_arbiter_pkg.sv
// Shared types and constants for the modulus-ROM read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package m_mem_read_arbiter_pkg;

    // Requester identities as carried in the tag id field
    localparam logic REQ_MMUL = 1'b0;
    localparam logic REQ_PRE  = 1'b1;

    // ROM address-to-q latency: ROM address register plus output register
    localparam int RD_LAT = 2;

    // In-flight read tag, travels alongside the ROM access
    typedef struct packed {
        logic valid;
        logic id;
        logic last;
    } tag_t;

    localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/m_mem_rr_arbiter.sv
// Two-way round-robin picker with a pointer register and one-hot grant.
// Latency: combinational grant; pointer moves to the loser on the cycle after a grant.
// Backpressure: none; grant only offered while i_en is high.
module m_mem_rr_arbiter
    import m_mem_read_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_id,
    output logic       o_vld
);

    logic r_ptr;
    logic w_id;

    // Winner: pointer breaks ties, a lone requester always wins
    always_comb begin
        w_id = REQ_MMUL;
        if (i_req == 2'b11) begin
            w_id = r_ptr;
        end else if (i_req[1]) begin
            w_id = REQ_PRE;
        end
        o_vld = i_en && (i_req != 2'b00);
        o_id  = w_id;
        o_gnt = 2'b00;
        if (o_vld) begin
            o_gnt = (w_id == REQ_PRE) ? 2'b10 : 2'b01;
        end
    end

    // After any grant the other requester gets priority next time
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= REQ_MMUL;
        end else if (o_vld) begin
            r_ptr <= ~w_id;
        end
    end

endmodule

// File: rtl/m_mem_read_arbiter.sv
// Shares the single modulus-ROM read port between two burst requesters, tags returned data.
// Latency: gnt at t -> first rd_valid at t+1+RD_LAT; one idle arbitration cycle between bursts.
// Backpressure: none; consumers must take rd_data on every rd_valid.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 7
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TOTAL_ADDR
`define TOTAL_ADDR 128
`endif

module m_mem_read_arbiter #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int TOTAL_ADDR = `TOTAL_ADDR,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int RD_LAT     = m_mem_read_arbiter_pkg::RD_LAT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] start_addr0,
    input  logic [ADDR_WIDTH-1:0] start_addr1,
    input  logic [LEN_WIDTH-1:0]  len0,
    input  logic [LEN_WIDTH-1:0]  len1,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  rd_valid,
    output logic                  rd_id,
    output logic                  rd_last,
    output logic [DATA_WIDTH-1:0] rd_data
);

    import m_mem_read_arbiter_pkg::*;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [LEN_WIDTH-1:0]  LP_MAX_LEN   = LEN_WIDTH'(TOTAL_ADDR);
    localparam logic [LEN_WIDTH-1:0]  LP_LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(TOTAL_ADDR - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE  = ADDR_WIDTH'(1);

    logic [0:0]            r_state;
    logic                  r_en;
    logic                  r_id;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_zdone;
    tag_t                  r_pipe [RD_LAT];

    logic                  w_arb_en;
    logic [1:0]            w_arb_gnt;
    logic                  w_arb_id;
    logic                  w_arb_vld;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]  w_sel_len;
    logic [LEN_WIDTH-1:0]  w_len_clip;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    tag_t                  w_push;
    tag_t                  w_tail;
    logic                  w_any_tag;
    logic [1:0]            w_tail_done;

    // Arbitration only in IDLE, and never in the first cycle out of reset
    assign w_arb_en = (r_state == ST_IDLE) && r_en;

    m_mem_rr_arbiter u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_arb_en),
        .i_req   (req),
        .o_gnt   (w_arb_gnt),
        .o_id    (w_arb_id),
        .o_vld   (w_arb_vld)
    );

    // Winner's burst parameters; oversize bursts are clipped to the ROM depth
    always_comb begin
        w_sel_addr = (w_arb_id == REQ_PRE) ? start_addr1 : start_addr0;
        w_sel_len  = (w_arb_id == REQ_PRE) ? len1 : len0;
        w_len_clip = (w_sel_len > LP_MAX_LEN) ? LP_MAX_LEN : w_sel_len;
        w_addr_nxt = (r_addr == LP_LAST_ADDR) ? '0 : (r_addr + LP_ADDR_ONE);
    end

    // Holds gnt low while reset is asserted and for the cycle right after release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en <= 1'b0;
        end else begin
            r_en <= 1'b1;
        end
    end

    // Burst FSM: grant in IDLE, one ROM address per cycle in ISSUE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_id        <= REQ_MMUL;
            r_remaining <= '0;
            r_addr      <= '0;
            r_zdone     <= 2'b00;
        end else begin
            r_zdone <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_vld) begin
                        r_id <= w_arb_id;
                        if (w_len_clip == '0) begin
                            r_zdone <= w_arb_gnt;
                        end else begin
                            r_addr      <= w_sel_addr;
                            r_remaining <= w_len_clip;
                            r_state     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_addr      <= w_addr_nxt;
                    r_remaining <= r_remaining - LP_LEN_ONE;
                    if (r_remaining == LP_LEN_ONE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag for the address being driven this cycle
    always_comb begin
        w_push = TAG_NONE;
        if (r_state == ST_ISSUE) begin
            w_push.valid = 1'b1;
            w_push.id    = r_id;
            w_push.last  = (r_remaining == LP_LEN_ONE);
        end
    end

    // Tag delay line matching the ROM read latency; reset drops in-flight reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= TAG_NONE;
            end
        end else begin
            r_pipe[0] <= w_push;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Busy covers reads still in flight after the FSM has returned to IDLE
    always_comb begin
        w_any_tag = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_any_tag = w_any_tag | r_pipe[i].valid;
        end
        w_tail      = r_pipe[RD_LAT-1];
        w_tail_done = 2'b00;
        if (w_tail.valid && w_tail.last) begin
            w_tail_done = (w_tail.id == REQ_PRE) ? 2'b10 : 2'b01;
        end
    end

    assign gnt         = w_arb_gnt;
    assign done        = w_tail_done | r_zdone;
    assign busy        = (r_state == ST_ISSUE) || w_any_tag;
    assign mem_address = r_addr;
    assign rd_valid    = w_tail.valid;
    assign rd_id       = w_tail.id;
    assign rd_last     = w_tail.last;
    assign rd_data     = mem_q;

endmodule

// File: tb/tb_m_mem_read_arbiter.sv
// Directed bench for m_mem_read_arbiter with a 2-cycle registered ROM model.
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
// A monitor logs every rd_valid word and done pulse with its cycle number.
module tb_m_mem_read_arbiter;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req;
    logic [6:0]  start_addr0, start_addr1;
    logic [7:0]  len0, len1;
    logic [1:0]  gnt, done;
    logic        busy;
    logic [6:0]  mem_address;
    logic [31:0] mem_q;
    logic        rd_valid, rd_id, rd_last;
    logic [31:0] rd_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] rom [128];
    logic [6:0]  rom_a;
    logic [31:0] rom_q;

    logic [31:0] q_dat [$];
    logic        q_id [$];
    logic        q_last [$];
    int          q_cyc [$];
    logic [1:0]  d_val [$];
    int          d_cyc [$];

    logic [31:0] e1_dat [4]  = '{32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007, 32'hC0DE0008};
    logic [31:0] e2_dat [4]  = '{32'hC0DE007E, 32'hC0DE007F, 32'hC0DE0000, 32'hC0DE0001};
    logic [31:0] e3_dat [12] = '{32'hC0DE000A, 32'hC0DE000B, 32'hC0DE000C,
                                 32'hC0DE0028, 32'hC0DE0029, 32'hC0DE002A,
                                 32'hC0DE000A, 32'hC0DE000B, 32'hC0DE000C,
                                 32'hC0DE0028, 32'hC0DE0029, 32'hC0DE002A};

    m_mem_read_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .start_addr0 (start_addr0),
        .start_addr1 (start_addr1),
        .len0        (len0),
        .len1        (len1),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .mem_address (mem_address),
        .mem_q       (mem_q),
        .rd_valid    (rd_valid),
        .rd_id       (rd_id),
        .rd_last     (rd_last),
        .rd_data     (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // ROM: address register then output register
    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'hC0DE0000 + i;
        rom_a = '0;
        rom_q = '0;
    end
    always @(posedge clock) begin
        rom_q <= rom[rom_a];
        rom_a <= mem_address;
    end
    assign mem_q = rom_q;

    // Monitor
    always @(negedge clock) begin
        #2;
        if (rd_valid) begin
            q_dat.push_back(rd_data);
            q_id.push_back(rd_id);
            q_last.push_back(rd_last);
            q_cyc.push_back(cyc);
        end
        if (done != 2'b00) begin
            d_val.push_back(done);
            d_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        q_dat.delete(); q_id.delete(); q_last.delete(); q_cyc.delete();
        d_val.delete(); d_cyc.delete();
    endtask

    // Called at a falling edge with req already set; returns the grant cycle
    task automatic wait_gnt(input string tag, input logic [1:0] exp, output int t);
        int k;
        k = 0;
        #1;
        while (gnt == 2'b00 && k < 30) begin
            @(negedge clock);
            #1;
            k++;
        end
        t = cyc;
        chk(tag, gnt, exp);
    endtask

    task automatic chk_word(input string tag, input int i, input logic [31:0] ed,
                            input logic eid, input logic elast, input int ecyc);
        if (i < q_dat.size()) begin
            chk($sformatf("%s_dat%0d", tag, i), q_dat[i], ed);
            chk($sformatf("%s_id%0d", tag, i), q_id[i], eid);
            chk($sformatf("%s_last%0d", tag, i), q_last[i], elast);
            chk($sformatf("%s_cyc%0d", tag, i), q_cyc[i], ecyc);
        end
    endtask

    initial begin
        int t;
        int ng;
        int nl;
        logic [1:0] g_val [4];
        int         g_cyc [4];

        reset_n = 1'b0; req = 2'b00;
        start_addr0 = '0; start_addr1 = '0; len0 = '0; len1 = '0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_last", rd_last, 1'b0);
        chk("rst_id", rd_id, 1'b0);
        chk("rst_addr", mem_address, 7'd0);
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock);

        // Single burst: requester 0, addr 5, 4 words
        clr();
        req = 2'b01; start_addr0 = 7'd5; len0 = 8'd4;
        wait_gnt("t1_gnt", 2'b01, t);
        @(negedge clock); req = 2'b00;
        #1; chk("t1_busy", busy, 1'b1);
        chk("t1_addr", mem_address, 7'd5);
        repeat (10) @(negedge clock);
        chk("t1_nwords", q_dat.size(), 4);
        for (int i = 0; i < 4; i++) chk_word("t1", i, e1_dat[i], 1'b0, i == 3, t + 3 + i);
        chk("t1_ndone", d_val.size(), 1);
        if (d_val.size() > 0) begin
            chk("t1_done", d_val[0], 2'b01);
            chk("t1_done_cyc", d_cyc[0], t + 6);
        end
        #1; chk("t1_idle_busy", busy, 1'b0);

        // Wrap: requester 1, addr 126, 4 words
        clr();
        req = 2'b10; start_addr1 = 7'd126; len1 = 8'd4;
        wait_gnt("t2_gnt", 2'b10, t);
        @(negedge clock); req = 2'b00;
        repeat (10) @(negedge clock);
        chk("t2_nwords", q_dat.size(), 4);
        for (int i = 0; i < 4; i++) chk_word("t2", i, e2_dat[i], 1'b1, i == 3, t + 3 + i);
        chk("t2_ndone", d_val.size(), 1);
        if (d_val.size() > 0) chk("t2_done", d_val[0], 2'b10);

        // Contention: both held, 3 words each
        clr();
        req = 2'b11; start_addr0 = 7'd10; start_addr1 = 7'd40; len0 = 8'd3; len1 = 8'd3;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            #1;
            if (gnt != 2'b00) begin
                g_val[ng] = gnt;
                g_cyc[ng] = cyc;
                ng++;
            end
            @(negedge clock);
        end
        req = 2'b00;
        chk("t3_ngnt", ng, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) chk($sformatf("t3_gnt%0d", k), g_val[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0 && k < ng) chk($sformatf("t3_gap%0d", k), g_cyc[k] - g_cyc[k-1], 4);
        end
        t = g_cyc[0];
        repeat (16) @(negedge clock);
        chk("t3_nwords", q_dat.size(), 12);
        for (int i = 0; i < 12; i++)
            chk_word("t3", i, e3_dat[i], (i / 3) % 2 == 1, i % 3 == 2, t + 3 + 4 * (i / 3) + (i % 3));
        chk("t3_ndone", d_val.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < d_val.size()) chk($sformatf("t3_done%0d", k), d_val[k], (k % 2 == 0) ? 2'b01 : 2'b10);

        // Zero length
        clr();
        req = 2'b01; start_addr0 = 7'd9; len0 = 8'd0;
        wait_gnt("t4_gnt", 2'b01, t);
        @(negedge clock); req = 2'b00;
        #1;
        chk("t4_done", done, 2'b01);
        chk("t4_done_cyc", cyc, t + 1);
        chk("t4_busy", busy, 1'b0);
        @(negedge clock); #1;
        chk("t4_busy2", busy, 1'b0);
        chk("t4_done_off", done, 2'b00);
        repeat (5) @(negedge clock);
        chk("t4_nwords", q_dat.size(), 0);
        chk("t4_ndone", d_val.size(), 1);

        // Reset mid-burst
        clr();
        req = 2'b01; start_addr0 = 7'd50; len0 = 8'd8;
        wait_gnt("t5_gnt", 2'b01, t);
        @(negedge clock); req = 2'b00;
        @(negedge clock);
        @(negedge clock);
        #1; chk("t5_live", rd_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("t5_valid", rd_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_addr", mem_address, 7'd0);
        chk("t5_gnt", gnt, 2'b00);
        chk("t5_done", done, 2'b00);
        chk("t5_last", rd_last, 1'b0);
        clr();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
        chk("t5_nwords_after", q_dat.size(), 0);
        chk("t5_ndone_after", d_val.size(), 0);
        req = 2'b01; start_addr0 = 7'd20; len0 = 8'd2;
        wait_gnt("t5_regnt", 2'b01, t);
        @(negedge clock); req = 2'b00;
        repeat (8) @(negedge clock);
        chk("t5_nwords", q_dat.size(), 2);
        chk_word("t5", 0, 32'hC0DE0014, 1'b0, 1'b0, t + 3);
        chk_word("t5", 1, 32'hC0DE0015, 1'b0, 1'b1, t + 4);

        // Oversize: 200 words clipped to 128
        clr();
        req = 2'b10; start_addr1 = 7'd0; len1 = 8'd200;
        wait_gnt("t6_gnt", 2'b10, t);
        @(negedge clock); req = 2'b00;
        repeat (140) @(negedge clock);
        chk("t6_nwords", q_dat.size(), 128);
        nl = 0;
        foreach (q_last[i]) if (q_last[i]) nl++;
        chk("t6_nlast", nl, 1);
        if (q_dat.size() == 128) begin
            chk("t6_first", q_dat[0], 32'hC0DE0000);
            chk("t6_lastdat", q_dat[127], 32'hC0DE007F);
            chk("t6_lastflag", q_last[127], 1'b1);
            chk("t6_span", q_cyc[127] - q_cyc[0], 127);
            chk("t6_start", q_cyc[0], t + 3);
        end
        chk("t6_ndone", d_val.size(), 1);
        #1; chk("t6_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
